auth_uart_rx: RTL and testbench
===============================

// Module: auth_uart_rx
//
// PURPOSE
//  Serial front end plus authorization FSM for the Segway BLE command path.
//  Receives 8N1 bytes on RX (from the BLE module / bench UART_tx) and decodes
//  the GO (0x47) and STOP (0x53) commands. Combines them with rider_off from the
//  steering/load-cell logic to produce pwr_up, consumed by balance control and
//  the steer-enable logic downstream.
//
// PARAMETERS
//  BAUD_CNT  2604   clk cycles per bit (50 MHz / 19200 baud); min 8
//  CMD_GO    8'h47  authorize byte ('G')
//  CMD_STOP  8'h53  de-authorize byte ('S')
//
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  RX         in   1  async serial line, idle high
//  rider_off  in   1  level, 1 = no rider weight on load cells
//  pwr_up     out  1  registered; 1 = Segway authorized to run
//  rx_byte    out  8  last received byte; held until next valid byte
//  rx_vld     out  1  one-cycle pulse, rx_byte updated this cycle
//  frame_err  out  1  one-cycle pulse on bad stop bit (AUTH_FRAME_ERR_EN only; else tied 0)
//
// BEHAVIOUR
//  Reset: pwr_up=0, rx_byte=8'h00, rx_vld=0, frame_err=0, both FSMs to idle,
//   RX synchronizer (2 flops) preset to 1. Reset mid-frame discards the frame.
//  RX path: 2-flop synchronizer, then falling-edge detect in IDLE.
//  Receiver FSM IDLE->START->DATA->STOP->IDLE:
//   - IDLE: synchronized RX falls -> START, baud_cnt loaded with BAUD_CNT/2.
//   - START: at baud_cnt==0 sample RX; 1 = glitch -> IDLE (no pulse);
//     0 -> DATA, baud_cnt=BAUD_CNT.
//   - DATA: 8 samples, one per BAUD_CNT, LSB first into shift reg; 3-bit bit_cnt.
//   - STOP: sample at mid stop bit; next cycle rx_byte<=shift, rx_vld=1, ->IDLE.
//     Back-to-back frames accepted: IDLE re-arms same cycle as rx_vld.
//  Auth FSM (advances only on rx_vld cycles or rider_off level):
//   - OFF:  rx_vld & byte==CMD_GO -> PWR1.
//   - PWR1: rx_vld & byte==CMD_STOP & rider_off -> OFF;
//           rx_vld & byte==CMD_STOP & !rider_off -> PWR2; other bytes ignored.
//   - PWR2: rx_vld & byte==CMD_GO -> PWR1 (GO wins over simultaneous rider_off);
//           else rider_off -> OFF.
//  pwr_up = (state!=OFF), registered: changes the cycle after rx_vld, or the
//   cycle after rider_off rises while in PWR2. Unknown bytes never change state.
//  STOP while OFF and GO while PWR1 are no-ops.
//  Latency: start-edge to rx_vld = 9.5*BAUD_CNT + ~4 cycles; pwr_up +1.
//
// CONFIGURATION
//  AUTH_FRAME_ERR_EN defined: stop-bit sample of 0 -> no rx_vld, rx_byte
//   unchanged, frame_err pulses 1 cycle, auth FSM unaffected, ->IDLE.
//  Not defined: stop bit not checked; every frame yields rx_vld; frame_err=0.
//
// TESTING
//  1. Assert rst 5 cycles -> pwr_up=0, rx_vld=0, rx_byte=0x00; RX idle 1000 cycles -> no rx_vld.
//  2. Send 0x47, rider_off=0 -> one rx_vld pulse, rx_byte=0x47, pwr_up=1 next cycle.
//  3. From PWR1 send 0x53, rider_off=0 -> pwr_up stays 1; raise rider_off -> pwr_up=0 within 2 cycles.
//  4. From PWR1 send 0x53 with rider_off=1 -> pwr_up=0 the cycle after rx_vld; send 0x41 -> pwr_up stays 0.
//  5. RX low 500 cycles then high -> no rx_vld; immediately send 0x47 -> received correctly.
//  6. AUTH_FRAME_ERR_EN: send 0x47 with stop bit 0 -> frame_err pulse, no rx_vld, pwr_up stays 0;
//     rst asserted mid-DATA of 0x47 -> pwr_up=0, no rx_vld after release.

Source files
------------

// File: rtl/auth_uart_rx.sv
// auth_uart_rx: 8N1 serial receiver plus GO/STOP authorization FSM producing pwr_up.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   RX         in   async serial line, idle high
//   rider_off  in   level, 1 = no rider weight on load cells
//   pwr_up     out  registered, 1 = authorized to run
//   rx_byte    out  last received byte, held until the next valid byte
//   rx_vld     out  one-cycle pulse, rx_byte updated this cycle
//   frame_err  out  one-cycle pulse on a bad stop bit
//
// Optional feature: define AUTH_FRAME_ERR_EN to check the stop bit; otherwise
// every frame yields rx_vld and frame_err stays 0.
module auth_uart_rx #(
    parameter int         BAUD_CNT = 2604,
    parameter logic [7:0] CMD_GO   = 8'h47,
    parameter logic [7:0] CMD_STOP = 8'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       frame_err
);
    localparam int CW = $clog2(BAUD_CNT + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    typedef enum logic [1:0] {A_OFF, A_PWR1, A_PWR2} au_st_t;

    rx_st_t rx_st, rx_nxt;
    au_st_t au_st, au_nxt;
    logic rx_s1, rx_s2, rx_d;
    logic [CW-1:0] baud_cnt, cnt_nxt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic tick, fall, done, bad, go, stop;

    assign tick = baud_cnt == '0;
    assign fall = rx_d & ~rx_s2;
    assign go   = rx_vld && rx_byte == CMD_GO;
    assign stop = rx_vld && rx_byte == CMD_STOP;

    // Count runs N-1..0 so one bit period is exactly BAUD_CNT cycles; IDLE keeps
    // the half-bit value loaded so START lands mid start bit.
    always_comb begin
        rx_nxt  = rx_st;
        cnt_nxt = tick ? CW'(BAUD_CNT - 1) : baud_cnt - CW'(1);
        done    = 1'b0;
        bad     = 1'b0;
        case (rx_st)
            R_IDLE: begin
                cnt_nxt = CW'(BAUD_CNT / 2);
                rx_nxt  = fall ? R_START : R_IDLE;
            end
            R_START: rx_nxt = tick ? (rx_s2 ? R_IDLE : R_DATA) : R_START;
            R_DATA:  rx_nxt = (tick && bit_cnt == 3'd7) ? R_STOP : R_DATA;
            R_STOP: begin
                rx_nxt = tick ? R_IDLE : R_STOP;
`ifdef AUTH_FRAME_ERR_EN
                done   = tick & rx_s2;
                bad    = tick & ~rx_s2;
`else
                done   = tick;
`endif
            end
            default: rx_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        au_nxt = au_st;
        case (au_st)
            A_OFF:   au_nxt = go ? A_PWR1 : A_OFF;
            A_PWR1:  au_nxt = stop ? (rider_off ? A_OFF : A_PWR2) : A_PWR1;
            A_PWR2:  au_nxt = go ? A_PWR1 : (rider_off ? A_OFF : A_PWR2);
            default: au_nxt = A_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st <= R_IDLE;
            au_st <= A_OFF;
        end else begin
            rx_st <= rx_nxt;
            au_st <= au_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_d      <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rx_byte   <= 8'h00;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
            pwr_up    <= 1'b0;
        end else begin
            rx_s1     <= RX;
            rx_s2     <= rx_s1;
            rx_d      <= rx_s2;
            baud_cnt  <= cnt_nxt;
            bit_cnt   <= rx_st != R_DATA ? 3'd0 : bit_cnt + (tick ? 3'd1 : 3'd0);
            shift     <= (rx_st == R_DATA && tick) ? {rx_s2, shift[7:1]} : shift;
            rx_byte   <= done ? shift : rx_byte;
            rx_vld    <= done;
            frame_err <= bad;
            pwr_up    <= au_nxt != A_OFF;
        end
    end
endmodule

// File: tb/tb_auth_uart_rx.sv
// tb_auth_uart_rx: scoreboard bench for auth_uart_rx (bytes, pwr_up, glitch, reset).
module tb_auth_uart_rx;
    localparam int BAUD = 32;

    typedef struct {
        logic [7:0] b;
        logic       p;
    } exp_t;

    logic clk = 1'b0, rst, RX, rider_off, pwr_up, rx_vld, frame_err;
    logic [7:0] rx_byte;
    exp_t q[$];
    int n_chk = 0, n_fail = 0, vld_cnt = 0, ferr_cnt = 0, n_sent = 0;

    auth_uart_rx #(.BAUD_CNT(BAUD)) dut (
        .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
        .pwr_up(pwr_up), .rx_byte(rx_byte), .rx_vld(rx_vld), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        RX = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic sb);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(sb);
    endtask

    // Queue the expected byte and the pwr_up value required the cycle after rx_vld.
    task automatic send(input logic [7:0] b, input logic exp_p);
        exp_t e;
        e.b = b;
        e.p = exp_p;
        q.push_back(e);
        n_sent++;
        frame(b, 1'b1);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (frame_err) ferr_cnt++;
        if (rx_vld) begin
            vld_cnt++;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rx_vld: got byte %0h expected no pulse", rx_byte);
            end else begin
                e = q.pop_front();
                chk("rx_byte", rx_byte, e.b);
                @(negedge clk);
                chk("pwr_up_after_vld", pwr_up, e.p);
            end
        end
    end

    initial begin
        int v;
        RX = 1'b1;
        rider_off = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_pwr_up", pwr_up, 0);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_no_vld", vld_cnt, 0);

        send(8'h47, 1'b1);
        send(8'h41, 1'b1);
        send(8'h47, 1'b1);
        send(8'h53, 1'b1);
        rider_off = 1'b1;
        repeat (2) @(negedge clk);
        chk("rider_off_drop", pwr_up, 0);
        rider_off = 1'b0;
        send(8'h53, 1'b0);

        send(8'h47, 1'b1);
        rider_off = 1'b1;
        send(8'h53, 1'b0);
        send(8'h41, 1'b0);
        rider_off = 1'b0;
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        chk("pwr_after_unknown", pwr_up, 0);

        v = vld_cnt;
`ifdef AUTH_FRAME_ERR_EN
        frame(8'h47, 1'b0);
        chk("bad_stop_ferr", ferr_cnt, 1);
        chk("bad_stop_no_vld", vld_cnt, v);
        chk("bad_stop_pwr", pwr_up, 0);
        chk("bad_stop_byte_held", rx_byte, 8'hFF);
`else
        // Stop bit is unchecked here, so the frame is accepted and authorizes.
        n_sent++;
        q.push_back('{8'h47, 1'b1});
        frame(8'h47, 1'b0);
`endif
        bit_time(1'b1);

        v = vld_cnt;
        RX = 1'b0;
        repeat (10) @(negedge clk);
        bit_time(1'b1);
        chk("glitch_no_vld", vld_cnt, v);
        send(8'h47, 1'b1);
        send(8'h53, 1'b1);
        send(8'h47, 1'b1);

        v = vld_cnt;
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        RX = 1'b1;
        rst = 1'b0;
        repeat (20 * BAUD) @(negedge clk);
        chk("midframe_rst_no_vld", vld_cnt, v);
        chk("midframe_rst_pwr", pwr_up, 0);
        chk("midframe_rst_byte", rx_byte, 8'h00);

        chk("vld_total", vld_cnt, n_sent);
        chk("queue_drained", q.size(), 0);
`ifndef AUTH_FRAME_ERR_EN
        chk("no_frame_err", ferr_cnt, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
